bpsk_frame_sync: RTL and testbench

Consumes the hard-decision bit stream from the BPSK demapper (bit plus valid strobe, one bit per valid cycle). Hunts for a fixed sync word and resolves the BPSK 180-degree phase ambiguity by also matching the inverted word. After lock, packs a fixed-length payload into bytes (MSB first) with start/end-of-frame flags for the downstream byte consumer (FIFO/packet parser).

---
 rtl/bpsk_pkg.sv | 13 +
 rtl/bpsk_sync_detect.sv | 45 ++++
 rtl/bpsk_frame_sync.sv | 101 ++++++++++
 tb/tb_bpsk_frame_sync.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpsk_pkg.sv
// rtl/bpsk_pkg.sv - shared BPSK framing constants and state encoding
package bpsk_pkg;

    localparam int          BYTE_W        = 8;
    localparam int          DEF_SYNC_LEN  = 16;
    localparam logic [15:0] DEF_SYNC_WORD = 16'hF628;

    typedef enum logic {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } sync_state_t;

endpackage

// File: rtl/bpsk_sync_detect.sv
// rtl/bpsk_sync_detect.sv - sliding sync-word detector matching both BPSK polarities
module bpsk_sync_detect
    import bpsk_pkg::*;
#(
    parameter int                  SYNC_LEN  = DEF_SYNC_LEN,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD = DEF_SYNC_WORD
) (
    input  logic CLK,
    input  logic RST,
    input  logic shift_en,
    input  logic clear,
    input  logic bit_i,
    output logic match,
    output logic match_inv
);

    localparam int CNT_W = $clog2(SYNC_LEN + 1);

    logic [SYNC_LEN-1:0] sreg;
    logic [SYNC_LEN-1:0] shifted;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic                full;

    // Matching looks at the window including the bit being shifted in this cycle.
    assign shifted   = {sreg[SYNC_LEN-2:0], bit_i};
    assign cnt_next  = (cnt == CNT_W'(SYNC_LEN)) ? cnt : cnt + 1'b1;
    assign full      = (cnt_next == CNT_W'(SYNC_LEN));
    assign match     = shift_en && full && (shifted == SYNC_WORD);
    assign match_inv = shift_en && full && (shifted == ~SYNC_WORD);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (clear) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (shift_en) begin
            sreg <= shifted;
            cnt  <= cnt_next;
        end
    end

endmodule

// File: rtl/bpsk_frame_sync.sv
// rtl/bpsk_frame_sync.sv - BPSK frame synchroniser with polarity resolution and byte packer
module bpsk_frame_sync
    import bpsk_pkg::*;
#(
    parameter int                  SYNC_LEN      = DEF_SYNC_LEN,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD     = DEF_SYNC_WORD,
    parameter int                  PAYLOAD_BYTES = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              valid_i,
    input  logic              bit_i,
    output logic              valid_o,
    output logic [BYTE_W-1:0] data_o,
    output logic              sof_o,
    output logic              eof_o,
    output logic              locked_o,
    output logic              inv_o
);

    sync_state_t       state;
    logic [BYTE_W-1:0] byte_sr;
    logic [BYTE_W-1:0] byte_next;
    logic [2:0]        bit_cnt;
    logic [7:0]        byte_cnt;
    logic              d_bit;
    logic              last_byte;
    logic              match;
    logic              match_inv;

    assign d_bit     = bit_i ^ inv_o;
    assign byte_next = {byte_sr[BYTE_W-2:0], d_bit};
    assign last_byte = (byte_cnt == 8'(PAYLOAD_BYTES - 1));

    // Held clear for the whole payload so each hunt starts from an empty window.
    bpsk_sync_detect #(
        .SYNC_LEN  (SYNC_LEN),
        .SYNC_WORD (SYNC_WORD)
    ) u_detect (
        .CLK       (CLK),
        .RST       (RST),
        .shift_en  (valid_i && (state == HUNT)),
        .clear     (state == PAYLOAD),
        .bit_i     (bit_i),
        .match     (match),
        .match_inv (match_inv)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= HUNT;
            byte_sr  <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            valid_o  <= 1'b0;
            data_o   <= '0;
            sof_o    <= 1'b0;
            eof_o    <= 1'b0;
            locked_o <= 1'b0;
            inv_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            sof_o   <= 1'b0;
            eof_o   <= 1'b0;
            if (valid_i) begin
                case (state)
                    HUNT: begin
                        if (match || match_inv) begin
                            state    <= PAYLOAD;
                            locked_o <= 1'b1;
                            inv_o    <= match_inv;
                            bit_cnt  <= '0;
                            byte_cnt <= '0;
                        end
                    end
                    PAYLOAD: begin
                        byte_sr <= byte_next;
                        if (bit_cnt == 3'(BYTE_W - 1)) begin
                            bit_cnt <= '0;
                            data_o  <= byte_next;
                            valid_o <= 1'b1;
                            sof_o   <= (byte_cnt == 8'd0);
                            eof_o   <= last_byte;
                            if (last_byte) begin
                                state    <= HUNT;
                                locked_o <= 1'b0;
                                byte_cnt <= '0;
                            end else begin
                                byte_cnt <= byte_cnt + 8'd1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bpsk_frame_sync.sv
// tb/tb_bpsk_frame_sync.sv - directed self-checking bench for bpsk_frame_sync
module tb_bpsk_frame_sync;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       valid_i = 1'b0;
    logic       bit_i = 1'b0;
    logic       valid_o;
    logic [7:0] data_o;
    logic       sof_o;
    logic       eof_o;
    logic       locked_o;
    logic       inv_o;

    int n_checks = 0;
    int n_fail   = 0;
    int bits_in  = 0;
    int bad_strobe = 0;
    logic prev_v = 1'b0;

    logic [7:0] q_data[$];
    logic       q_sof[$];
    logic       q_eof[$];
    logic       q_inv[$];
    logic       q_lock[$];
    int         q_pos[$];

    localparam logic [31:0] PAY_A = 32'h3CA500FF;
    localparam logic [31:0] PAY_S = 32'hF6281122;

    bpsk_frame_sync dut (
        .CLK      (CLK),
        .RST      (RST),
        .valid_i  (valid_i),
        .bit_i    (bit_i),
        .valid_o  (valid_o),
        .data_o   (data_o),
        .sof_o    (sof_o),
        .eof_o    (eof_o),
        .locked_o (locked_o),
        .inv_o    (inv_o)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        prev_v <= valid_i && RST;
        if (valid_i && RST) bits_in <= bits_in + 1;
    end

    // Output monitor: strobes are recorded with the number of valid bits sampled so far.
    always @(negedge CLK) begin
        if (RST) begin
            if (valid_o) begin
                if (!prev_v) bad_strobe++;
                q_data.push_back(data_o);
                q_sof.push_back(sof_o);
                q_eof.push_back(eof_o);
                q_inv.push_back(inv_o);
                q_lock.push_back(locked_o);
                q_pos.push_back(bits_in);
            end
            if ((sof_o || eof_o) && !valid_o) bad_strobe++;
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    task automatic clear_q();
        q_data.delete(); q_sof.delete(); q_eof.delete();
        q_inv.delete(); q_lock.delete(); q_pos.delete();
    endtask

    task automatic send_bit(input logic b, input int gap);
        repeat (gap) begin
            @(negedge CLK);
            valid_i = 1'b0;
            bit_i   = 1'($urandom_range(0, 1));
        end
        @(negedge CLK);
        valid_i = 1'b1;
        bit_i   = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            valid_i = 1'b0;
            bit_i   = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [31:0] w, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i], gap);
    endtask

    task automatic send_frame(input logic pol, input logic [31:0] pay, input int gap);
        send_bits(pol ? 32'h000009D7 : 32'h0000F628, 16, gap);
        send_bits(pol ? ~pay : pay, 32, gap);
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({valid_o, data_o, sof_o, eof_o, locked_o, inv_o} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected all zero", {valid_o, data_o, sof_o, eof_o, locked_o, inv_o});
        end
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_continuous();
        int base;
        logic [7:0] exp_d[4] = '{8'h3C, 8'hA5, 8'h00, 8'hFF};
        clear_q();
        base = bits_in;
        send_frame(1'b0, PAY_A, 0);
        idle(1);
        n_checks++;
        if (locked_o !== 1'b0 || eof_o !== 1'b1) begin
            n_fail++;
            $display("FAIL cont_last_edge: locked=%b eof=%b expected locked=0 eof=1", locked_o, eof_o);
        end
        idle(1);
        n_checks++;
        if (locked_o !== 1'b0 || valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_after: locked=%b valid=%b expected 0 0", locked_o, valid_o);
        end
        n_checks++;
        if (q_data.size() != 4) begin
            n_fail++;
            $display("FAIL cont_count: got %0d strobes expected 4", q_data.size());
        end
        for (int i = 0; i < q_data.size() && i < 4; i++) begin
            n_checks++;
            if (q_data[i] !== exp_d[i] || q_sof[i] !== (i == 0) || q_eof[i] !== (i == 3) ||
                q_inv[i] !== 1'b0 || q_lock[i] !== (i != 3) || q_pos[i] != base + 24 + 8 * i) begin
                n_fail++;
                $display("FAIL cont_byte%0d: data=%h sof=%b eof=%b inv=%b lock=%b pos=%0d expected data=%h sof=%b eof=%b inv=0 lock=%b pos=%0d",
                         i, q_data[i], q_sof[i], q_eof[i], q_inv[i], q_lock[i], q_pos[i] - base,
                         exp_d[i], (i == 0), (i == 3), (i != 3), 24 + 8 * i);
            end
        end
    endtask

    task automatic test_inverted();
        logic [7:0] exp_d[4] = '{8'h3C, 8'hA5, 8'h00, 8'hFF};
        clear_q();
        send_frame(1'b1, PAY_A, 0);
        idle(3);
        n_checks++;
        if (q_data.size() != 4 || inv_o !== 1'b1) begin
            n_fail++;
            $display("FAIL inv_count: got %0d strobes inv=%b expected 4 inv=1", q_data.size(), inv_o);
        end
        for (int i = 0; i < q_data.size() && i < 4; i++) begin
            n_checks++;
            if (q_data[i] !== exp_d[i] || q_inv[i] !== 1'b1 || q_sof[i] !== (i == 0) || q_eof[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL inv_byte%0d: data=%h inv=%b sof=%b eof=%b expected data=%h inv=1",
                         i, q_data[i], q_inv[i], q_sof[i], q_eof[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_gapped();
        int base;
        logic [7:0] exp_d[4] = '{8'h3C, 8'hA5, 8'h00, 8'hFF};
        clear_q();
        bad_strobe = 0;
        base = bits_in;
        send_frame(1'b0, PAY_A, 2);
        idle(4);
        n_checks++;
        if (q_data.size() != 4 || bad_strobe != 0) begin
            n_fail++;
            $display("FAIL gap_count: got %0d strobes, %0d stray, expected 4 and 0", q_data.size(), bad_strobe);
        end
        for (int i = 0; i < q_data.size() && i < 4; i++) begin
            n_checks++;
            if (q_data[i] !== exp_d[i] || q_pos[i] != base + 24 + 8 * i || q_inv[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL gap_byte%0d: data=%h pos=%0d inv=%b expected data=%h pos=%0d inv=0",
                         i, q_data[i], q_pos[i] - base, q_inv[i], exp_d[i], 24 + 8 * i);
            end
        end
    endtask

    task automatic test_false_sync();
        logic [7:0] exp_d[4] = '{8'h3C, 8'hA5, 8'h00, 8'hFF};
        clear_q();
        send_bits(32'h0000F629, 16, 0);
        send_bits(32'h0000005A, 8, 0);
        idle(2);
        n_checks++;
        if (q_data.size() != 0 || locked_o !== 1'b0) begin
            n_fail++;
            $display("FAIL false_nolock: strobes=%0d locked=%b expected 0 0", q_data.size(), locked_o);
        end
        send_frame(1'b0, PAY_A, 0);
        idle(3);
        n_checks++;
        if (q_data.size() != 4) begin
            n_fail++;
            $display("FAIL false_relock: got %0d strobes expected 4", q_data.size());
        end
        for (int i = 0; i < q_data.size() && i < 4; i++) begin
            n_checks++;
            if (q_data[i] !== exp_d[i]) begin
                n_fail++;
                $display("FAIL false_byte%0d: data=%h expected %h", i, q_data[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int base;
        logic [7:0] exp_d[8] = '{8'hF6, 8'h28, 8'h11, 8'h22, 8'h3C, 8'hA5, 8'h00, 8'hFF};
        clear_q();
        base = bits_in;
        send_frame(1'b0, PAY_S, 0);
        send_frame(1'b0, PAY_A, 0);
        idle(3);
        n_checks++;
        if (q_data.size() != 8) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d strobes expected 8", q_data.size());
        end
        for (int i = 0; i < q_data.size() && i < 8; i++) begin
            n_checks++;
            if (q_data[i] !== exp_d[i] || q_sof[i] !== (i % 4 == 0) || q_eof[i] !== (i % 4 == 3) ||
                q_pos[i] != base + 24 + 8 * (i % 4) + 48 * (i / 4)) begin
                n_fail++;
                $display("FAIL b2b_byte%0d: data=%h sof=%b eof=%b pos=%0d expected data=%h sof=%b eof=%b pos=%0d",
                         i, q_data[i], q_sof[i], q_eof[i], q_pos[i] - base, exp_d[i],
                         (i % 4 == 0), (i % 4 == 3), 24 + 8 * (i % 4) + 48 * (i / 4));
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] exp_d[4] = '{8'h3C, 8'hA5, 8'h00, 8'hFF};
        clear_q();
        send_bits(32'h000009D7, 16, 0);
        send_bits(~PAY_A >> 20, 12, 0);
        idle(1);
        n_checks++;
        if (locked_o !== 1'b1 || inv_o !== 1'b1 || q_data.size() != 1) begin
            n_fail++;
            $display("FAIL mid_prelock: locked=%b inv=%b strobes=%0d expected 1 1 1", locked_o, inv_o, q_data.size());
        end
        RST = 1'b0;
        #1;
        n_checks++;
        if ({valid_o, data_o, sof_o, eof_o, locked_o, inv_o} !== 13'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %b expected all zero", {valid_o, data_o, sof_o, eof_o, locked_o, inv_o});
        end
        idle(2);
        RST = 1'b1;
        clear_q();
        send_frame(1'b0, PAY_A, 0);
        idle(3);
        n_checks++;
        if (q_data.size() != 4) begin
            n_fail++;
            $display("FAIL mid_after_count: got %0d strobes expected 4", q_data.size());
        end
        for (int i = 0; i < q_data.size() && i < 4; i++) begin
            n_checks++;
            if (q_data[i] !== exp_d[i] || q_inv[i] !== 1'b0 || q_sof[i] !== (i == 0)) begin
                n_fail++;
                $display("FAIL mid_byte%0d: data=%h inv=%b sof=%b expected data=%h inv=0 sof=%b",
                         i, q_data[i], q_inv[i], q_sof[i], exp_d[i], (i == 0));
            end
        end
    endtask

    initial begin
        test_reset();
        idle(2);
        test_continuous();
        test_inverted();
        test_gapped();
        test_false_sync();
        test_back_to_back();
        test_reset_midframe();
        n_checks++;
        if (bad_strobe != 0) begin
            n_fail++;
            $display("FAIL stray_pulses: got %0d expected 0", bad_strobe);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
